// File: rtl/mon_stream_comb_if.sv
// Stream/result bundle between the integrator serializer, the comb stage
// and the readout logic. The master drives the serialized words and the
// error clear and receives the results; the comb block is the slave.
interface mon_stream_comb_if #(
    parameter int rwi = 28,
    parameter int dwo = 18,
    parameter int cw  = 4
);
    logic signed [rwi-1:0] stream_in;
    logic                  gate_in;
    logic                  err_clr;
    logic signed [dwo-1:0] d_out;
    logic                  d_valid;
    logic [cw-1:0]         d_chan;
    logic                  frame_done;
    logic                  err_overrun;
    logic                  err_short;

    modport master (
        output stream_in, gate_in, err_clr,
        input  d_out, d_valid, d_chan, frame_done, err_overrun, err_short
    );

    modport slave (
        input  stream_in, gate_in, err_clr,
        output d_out, d_valid, d_chan, frame_done, err_overrun, err_short
    );
endinterface

// File: rtl/mon_stream_comb.sv
// Second-order CIC comb for the two-channel monitor stream.
// Input handshake: a word is taken on every rising edge where gate_in is
// high; one contiguous gate burst is one frame, word k is channel k. There
// is no back-pressure: d_valid is a one-cycle strobe that the consumer
// must accept. Results appear two clocks after their input word.
module mon_stream_comb #(
    parameter int rwi   = 28,
    parameter int dwo   = 18,
    parameter int shift = 6,
    parameter int nchan = 2,
    parameter int cw    = 4
) (
    input logic              clk,
    input logic              rst_n,
    mon_stream_comb_if.slave bus
);
    localparam int aw = (nchan > 1) ? $clog2(nchan) : 1;
    localparam logic [cw:0] n_full = (cw + 1)'(nchan);
    localparam logic [cw:0] n_last = (cw + 1)'(nchan - 1);
    localparam logic signed [rwi-1:0] sat_max = rwi'((64'd1 << (dwo - 1)) - 64'd1);
    localparam logic signed [rwi-1:0] sat_min = ~sat_max;

    // Channel counter saturates at nchan so that excess words are recognised.
    logic [cw:0]  cnt;
    logic [1:0]   prime;
    logic [aw-1:0] idx;

    // Per-channel history: last input word and last first difference.
    logic signed [rwi-1:0] x_hist  [nchan];
    logic signed [rwi-1:0] y1_hist [nchan];

    logic accept, overrun_ev, short_ev, primed;
    logic signed [rwi-1:0] y1;

    // Stage 1 pipeline registers.
    logic                  s1_valid, s1_last;
    logic [cw-1:0]         s1_chan;
    logic signed [rwi-1:0] s1_y1, s1_y1p;

    // Stage 2 combinational results.
    logic signed [rwi-1:0] y, ys, y_sat;

    // Output registers.
    logic signed [dwo-1:0] d_out_r;
    logic                  d_valid_r, frame_done_r, err_overrun_r, err_short_r;
    logic [cw-1:0]         d_chan_r;

    assign idx = cnt[aw-1:0];

    // Framing decode, history read and first difference.
    always_comb begin
        accept     = bus.gate_in && (cnt != n_full);
        overrun_ev = bus.gate_in && (cnt == n_full);
        short_ev   = !bus.gate_in && (cnt != '0) && (cnt != n_full);
        primed     = (prime == 2'd2);
        y1         = bus.stream_in - x_hist[idx];
    end

    // Channel counter and prime counter (complete frames, saturating at 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            prime <= 2'd0;
        end else begin
            if (!bus.gate_in)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;
            if (accept && (cnt == n_last) && !primed)
                prime <= prime + 2'd1;
        end
    end

    // History RAM: not reset, priming hides whatever it holds.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_hist[idx]  <= bus.stream_in;
            y1_hist[idx] <= y1;
        end
    end

    // Stage 1 register: first difference and the previous one for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_chan  <= '0;
            s1_y1    <= '0;
            s1_y1p   <= '0;
        end else begin
            s1_valid <= accept && primed;
            s1_last  <= cnt == n_last;
            s1_chan  <= cnt[cw-1:0];
            s1_y1    <= y1;
            s1_y1p   <= y1_hist[idx];
        end
    end

    // Second difference, arithmetic scaling and saturation to dwo bits.
    always_comb begin
        y  = s1_y1 - s1_y1p;
        ys = y >>> shift;
        if (ys > sat_max)
            y_sat = sat_max;
        else if (ys < sat_min)
            y_sat = sat_min;
        else
            y_sat = ys;
    end

    // Stage 2 register: result presentation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_r      <= '0;
            d_valid_r    <= 1'b0;
            d_chan_r     <= '0;
            frame_done_r <= 1'b0;
        end else begin
            d_valid_r    <= s1_valid;
            frame_done_r <= s1_valid && s1_last;
            if (s1_valid) begin
                d_out_r  <= y_sat[dwo-1:0];
                d_chan_r <= s1_chan;
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun_r <= 1'b0;
            err_short_r   <= 1'b0;
        end else begin
            if (overrun_ev)
                err_overrun_r <= 1'b1;
            else if (bus.err_clr)
                err_overrun_r <= 1'b0;
            if (short_ev)
                err_short_r <= 1'b1;
            else if (bus.err_clr)
                err_short_r <= 1'b0;
        end
    end

    assign bus.d_out       = d_out_r;
    assign bus.d_valid     = d_valid_r;
    assign bus.d_chan      = d_chan_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.err_overrun = err_overrun_r;
    assign bus.err_short   = err_short_r;
endmodule

// File: tb/tb_mon_stream_comb.sv
// Bench for mon_stream_comb: two instances (shift 0 and shift 6) share one
// stimulus stream; a behavioural model queues expected results per instance.
module tb_mon_stream_comb;
    localparam int N  = 2;
    localparam int W  = 55; // {cycle[31:0], frame_done, chan[3:0], d_out[17:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    mon_stream_comb_if #(.rwi(28), .dwo(18), .cw(4)) bus0 ();
    mon_stream_comb_if #(.rwi(28), .dwo(18), .cw(4)) bus1 ();

    mon_stream_comb #(.rwi(28), .dwo(18), .shift(0), .nchan(N), .cw(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mon_stream_comb #(.rwi(28), .dwo(18), .shift(6), .nchan(N), .cw(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic signed [27:0] m_xp [N];
    logic signed [27:0] m_y1p [N];
    int   m_cnt = 0;
    int   m_prime = 0;
    logic m_ovr = 1'b0;
    logic m_short = 1'b0;
    logic signed [27:0] ch0_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] scale(input logic signed [27:0] yv, input int sh);
        logic signed [27:0] s;
        s = yv >>> sh;
        if (s > 28'sd131071) return 18'h1ffff;
        if (s < -28'sd131072) return 18'h20000;
        return s[17:0];
    endfunction

    // Model of what the next rising edge does with the driven inputs.
    task automatic model(input logic g, input logic signed [27:0] x, input logic clr);
        logic signed [27:0] y1, yv;
        logic ov, sh;
        ov = g && (m_cnt == N);
        sh = !g && (m_cnt != 0) && (m_cnt != N);
        m_ovr   = ov ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_short = sh ? 1'b1 : (clr ? 1'b0 : m_short);
        if (g && m_cnt < N) begin
            y1 = x - m_xp[m_cnt];
            yv = y1 - m_y1p[m_cnt];
            m_xp[m_cnt]  = x;
            m_y1p[m_cnt] = y1;
            if (m_prime == 2) begin
                exp_q0.push_back({32'(cyc + 2), m_cnt == N - 1, 4'(m_cnt), scale(yv, 0)});
                exp_q1.push_back({32'(cyc + 2), m_cnt == N - 1, 4'(m_cnt), scale(yv, 6)});
            end
            if (m_cnt == N - 1 && m_prime < 2) m_prime++;
            m_cnt++;
        end else if (!g) begin
            m_cnt = 0;
        end
    endtask

    // Driver: check flags from the previous edge, then drive the next cycle.
    task automatic step(input logic g, input logic [27:0] x, input logic clr);
        @(posedge clk);
        #1;
        chk("err_flags", {bus0.err_overrun, bus0.err_short, bus1.err_overrun, bus1.err_short},
            {m_ovr, m_short, m_ovr, m_short});
        bus0.gate_in = g; bus0.stream_in = x; bus0.err_clr = clr;
        bus1.gate_in = g; bus1.stream_in = x; bus1.err_clr = clr;
        if (g) begin
            if (m_cnt == 0) ch0_last = x;
        end
        model(g, x, clr);
    endtask

    task automatic frame(input logic [27:0] a, input logic [27:0] b);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        repeat (3) step(1'b0, 28'd0, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, {bus0.d_out, bus0.d_valid, bus0.d_chan, bus0.frame_done, bus0.err_overrun,
                  bus0.err_short, bus1.d_out, bus1.d_valid, bus1.d_chan, bus1.frame_done,
                  bus1.err_overrun, bus1.err_short}, 64'd0);
    endtask

    // Asynchronous reset between clock edges, then release.
    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outs("reset_async_outs");
        exp_q0.delete(); exp_q1.delete();
        m_cnt = 0; m_prime = 0; m_ovr = 1'b0; m_short = 1'b0;
        bus0.gate_in = 1'b0; bus1.gate_in = 1'b0;
        bus0.err_clr = 1'b0; bus1.err_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard: compare every strobe with the head of the expected queue.
    task automatic mon(input int which, input logic v, input logic [17:0] d,
                       input logic [3:0] c, input logic fd);
        logic [W-1:0] expv;
        if (v) begin
            expv = '1;
            if (which == 0 && exp_q0.size() > 0) expv = exp_q0.pop_front();
            if (which == 1 && exp_q1.size() > 0) expv = exp_q1.pop_front();
            chk(which == 0 ? "result_sh0" : "result_sh6",
                64'({32'(cyc), fd, c, d}), 64'(expv));
        end else begin
            chk("frame_done_idle", 64'(fd), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus0.d_valid, bus0.d_out, bus0.d_chan, bus0.frame_done);
            mon(1, bus1.d_valid, bus1.d_out, bus1.d_chan, bus1.frame_done);
        end
    end

    initial begin
        logic [27:0] a, b;
        bus0.gate_in = 1'b0; bus0.stream_in = '0; bus0.err_clr = 1'b0;
        bus1.gate_in = 1'b0; bus1.stream_in = '0; bus1.err_clr = 1'b0;
        for (int i = 0; i < N; i++) begin m_xp[i] = '0; m_y1p[i] = '0; end
        ch0_last = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outs("reset_outs");
        rst_n = 1'b1;

        // Priming and basic comb: results from the third frame on.
        frame(28'd0, 28'd5);
        frame(28'd10, 28'd5);
        frame(28'd30, 28'd5);
        frame(28'd60, 28'd5);

        // Wrap-around through the signed boundary; the third frame gives 0.
        frame(28'h7fffff6, 28'd5);
        frame(28'h8000000, 28'd5);
        frame(28'h800000a, 28'd5);

        // Saturation: +200000 then -200000 on channel 0.
        a = ch0_last + 28'd200010;
        frame(a, 28'd5);
        frame(a + 28'd10, 28'd5);
        frame(a + 28'd20 - 28'd200000, 28'd5);
        frame(a + 28'd30 - 28'd400000, 28'd5);

        // Overrun: a three-word burst, then clear, then clear colliding with overrun.
        step(1'b1, 28'd100, 1'b0);
        step(1'b1, 28'd7, 1'b0);
        step(1'b1, 28'd999, 1'b0);
        step(1'b0, 28'd0, 1'b0);
        step(1'b0, 28'd0, 1'b1);
        step(1'b0, 28'd0, 1'b0);
        step(1'b1, 28'd200, 1'b0);
        step(1'b1, 28'd9, 1'b0);
        step(1'b1, 28'd555, 1'b1);
        step(1'b0, 28'd0, 1'b0);
        step(1'b0, 28'd0, 1'b1);
        step(1'b0, 28'd0, 1'b0);

        // Short burst from reset: it must not count toward priming.
        async_reset();
        frame(28'd1000, 28'd50);
        step(1'b1, 28'd1234, 1'b0);
        repeat (3) step(1'b0, 28'd0, 1'b0);
        frame(28'd1100, 28'd70);
        frame(28'd1300, 28'd110);
        frame(28'd1600, 28'd160);
        step(1'b0, 28'd0, 1'b1);

        // Mid-burst reset, re-prime, then random traffic.
        step(1'b1, 28'd77, 1'b0);
        async_reset();
        frame(28'd3, 28'd4);
        frame(28'd8, 28'd9);
        for (int i = 0; i < 8; i++) begin
            a = 28'($urandom_range(0, 32'h0fffffff));
            b = ch0_last + 28'($urandom_range(0, 4000)) - 28'd2000;
            frame(b, a);
        end
        // Back-to-back bursts separated by one low cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 28'(i * 300), 1'b0);
            step(1'b1, 28'(i * i * 40), 1'b0);
            step(1'b0, 28'd0, 1'b0);
        end
        repeat (4) step(1'b0, 28'd0, 1'b0);

        chk("queue0_drained", 64'(exp_q0.size()), 64'd0);
        chk("queue1_drained", 64'(exp_q1.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
